// File: rtl/fifo_sync_param_if.sv
// rtl/fifo_sync_param_if.sv - producer/consumer handshake and status bundle for fifo_sync_param
interface fifo_sync_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                  write;
    logic                  read;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic [AW:0]           fill_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  fifo_overflow;
    logic                  fifo_underflow;

    modport master (
        output write, read, data_in, clr_err,
        input  data_out, rd_valid, fill_count, fifo_full, fifo_empty,
               almost_full, almost_empty, fifo_overflow, fifo_underflow
    );

    modport slave (
        input  write, read, data_in, clr_err,
        output data_out, rd_valid, fill_count, fifo_full, fifo_empty,
               almost_full, almost_empty, fifo_overflow, fifo_underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with occupancy, threshold flags and sticky errors
module fifo_sync_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    fifo_sync_param_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  rd_valid_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  full;
    logic                  empty;
    logic                  rd_acc;
    logic                  wr_acc;

    assign full   = (count == DEPTH_C);
    assign empty  = (count == '0);
    assign rd_acc = bus.read & ~empty;
    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign wr_acc = bus.write & (~full | rd_acc);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                dout_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // A fresh error in the clearing cycle keeps the flag set.
            ovf_q <= (bus.write & ~wr_acc) | (ovf_q & ~bus.clr_err);
            unf_q <= (bus.read & empty)    | (unf_q & ~bus.clr_err);
        end
    end

    assign bus.data_out       = dout_q;
    assign bus.rd_valid       = rd_valid_q;
    assign bus.fill_count     = count;
    assign bus.fifo_full      = full;
    assign bus.fifo_empty     = empty;
    assign bus.almost_full    = (count >= AF_C);
    assign bus.almost_empty   = (count <= AE_C);
    assign bus.fifo_overflow  = ovf_q;
    assign bus.fifo_underflow = unf_q;
endmodule
